jk_bank_ctrl: RTL and testbench

Round-robin controller that shares one W-bit bank of JK flip-flops between R requesters. Each requester issues a masked JK command (hold/count, clear, set, toggle). The controller arbitrates, grants one requester per transaction and drives the bank's J/K vectors for exactly one clock. It sits between software-style command sources and the JK storage primitives, and is the only writer of the bank.

---
 rtl/jk_bank_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// ---------------------------------------------------------------------------
// jk_bank_ctrl
// Round-robin controller that lets R requesters share a single W-bit bank of
// JK flip-flops. One requester is granted per transaction; its masked command
// is latched on the grant edge and applied to the bank on the following edge.
//
// Parameters:
//   W      width of the JK bank (1..16)
//   R      number of requesters (2..8)
//
// Ports:
//   clk    in   1     rising-edge clock
//   rst    in   1     synchronous active-high reset
//   req    in   R     per-requester request level
//   op     in   2R    per-requester command [2r+1:2r]
//                     00 hold/count, 01 clear, 10 set, 11 toggle
//   mask   in   W*R   per-requester bit mask [W*r+W-1:W*r], 1 = bit affected
//   gnt    out  R     one-hot grant (registered)
//   done   out  1     one-cycle pulse, bank update visible on q
//   busy   out  1     high while a granted command is pending
//   q      out  W     bank state
//   q_bar  out  W     ~q
//
// Configuration macro: JK_BANK_CTRL_COUNT_EN
//   defined   : op 00 increments the masked bits as a packed counter
//   undefined : op 00 holds every bit
// ---------------------------------------------------------------------------
module jk_bank_ctrl #(
    parameter int W = 4,
    parameter int R = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [R-1:0]     req,
    input  logic [2*R-1:0]   op,
    input  logic [W*R-1:0]   mask,
    output logic [R-1:0]     gnt,
    output logic             done,
    output logic             busy,
    output logic [W-1:0]     q,
    output logic [W-1:0]     q_bar
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [1:0]      r_op;
    logic [W-1:0]    r_mask;
    logic [W-1:0]    r_q;
    logic [R-1:0]    r_gnt;
    logic            r_done;
    logic            r_busy;

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [W-1:0]    w_j;
    logic [W-1:0]    w_k;
    logic [W-1:0]    w_q_next;

    // Arbitration: first active request scanning upward from r_ptr with wrap.
    // The sum is one bit wider than the pointer so ptr+k never overflows
    // before the wrap subtraction.
    always_comb begin
        logic [PW:0] v_sum;
        w_found  = 1'b0;
        w_winner = '0;
        v_sum    = '0;
        for (int k = 0; k < R; k++) begin
            v_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (v_sum >= (PW+1)'(R)) begin
                v_sum = v_sum - (PW+1)'(R);
            end else begin
                v_sum = v_sum;
            end
            if (!w_found && req[v_sum[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = v_sum[PW-1:0];
            end else begin
                w_found  = w_found;
                w_winner = w_winner;
            end
        end
    end

    // JK vector generation from the latched command; unmasked bits always hold.
`ifdef JK_BANK_CTRL_COUNT_EN
    // Count mode: a masked bit toggles only when every lower masked bit is 1,
    // so the carry chain simply skips unmasked positions.
    always_comb begin
        logic v_carry;
        w_j     = '0;
        w_k     = '0;
        v_carry = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (r_mask[i]) begin
                case (r_op)
                    2'b00: begin
                        w_j[i]  = v_carry;
                        w_k[i]  = v_carry;
                        v_carry = v_carry & r_q[i];
                    end
                    2'b01:   begin w_j[i] = 1'b0; w_k[i] = 1'b1; end
                    2'b10:   begin w_j[i] = 1'b1; w_k[i] = 1'b0; end
                    2'b11:   begin w_j[i] = 1'b1; w_k[i] = 1'b1; end
                    default: begin w_j[i] = 1'b0; w_k[i] = 1'b0; end
                endcase
            end else begin
                w_j[i] = 1'b0;
                w_k[i] = 1'b0;
            end
        end
    end
`else
    // Hold mode: op 00 leaves every bit alone.
    always_comb begin
        w_j = '0;
        w_k = '0;
        for (int i = 0; i < W; i++) begin
            if (r_mask[i]) begin
                case (r_op)
                    2'b01:   begin w_j[i] = 1'b0; w_k[i] = 1'b1; end
                    2'b10:   begin w_j[i] = 1'b1; w_k[i] = 1'b0; end
                    2'b11:   begin w_j[i] = 1'b1; w_k[i] = 1'b1; end
                    default: begin w_j[i] = 1'b0; w_k[i] = 1'b0; end
                endcase
            end else begin
                w_j[i] = 1'b0;
                w_k[i] = 1'b0;
            end
        end
    end
`endif

    // Characteristic JK equation applied bitwise: q+ = J&~q | ~K&q.
    assign w_q_next = (w_j & ~r_q) | (~w_k & r_q);

    // Controller FSM, command latch, bank state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_op    <= 2'b00;
            r_mask  <= '0;
            r_q     <= '0;
            r_gnt   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_found) begin
                        r_gnt   <= R'(1) << w_winner;
                        r_win   <= w_winner;
                        r_op    <= op[2*int'(w_winner) +: 2];
                        r_mask  <= mask[W*int'(w_winner) +: W];
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end else begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    r_q     <= w_q_next;
                    // Pointer only moves on a completed transaction.
                    if (r_win == PW'(R-1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_win + PW'(1);
                    end
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign busy  = r_busy;
    assign q     = r_q;
    assign q_bar = ~r_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_ctrl
// Directed bench for jk_bank_ctrl (W=4, R=3). Expected bank values and grant
// orders are queued when stimulus is driven and popped when the controller
// reports completion or a grant. Inputs change and outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_jk_bank_ctrl;

    localparam int W = 4;
    localparam int R = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [R-1:0]     req;
    logic [2*R-1:0]   op;
    logic [W*R-1:0]   mask;
    logic [R-1:0]     gnt;
    logic             done;
    logic             busy;
    logic [W-1:0]     q;
    logic [W-1:0]     q_bar;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [15:0] exp_q_queue[$];
    logic [15:0] exp_g_queue[$];

    jk_bank_ctrl #(.W(W), .R(R)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .mask  (mask),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .q     (q),
        .q_bar (q_bar)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_q(output logic [15:0] v);
        if (exp_q_queue.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL sb_q_empty: observed empty queue expected entry");
            v = 16'hxxxx;
        end else begin
            v = exp_q_queue.pop_front();
        end
    endtask

    task automatic pop_g(output logic [15:0] v);
        if (exp_g_queue.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL sb_g_empty: observed empty queue expected entry");
            v = 16'hxxxx;
        end else begin
            v = exp_g_queue.pop_front();
        end
    endtask

    // One full transaction from requester r, entered just after a falling
    // edge. During GRANT the request is dropped and op/mask are inverted so
    // that any late sampling of the inputs would change the result.
    task automatic txn(input int r, input logic [1:0] o, input logic [3:0] m,
                       input logic [3:0] eq, input string tag);
        logic [15:0] e;
        logic [R-1:0] g;
        g = '0;
        g[r] = 1'b1;
        req = '0;
        req[r] = 1'b1;
        op = '0;
        op[2*r +: 2] = o;
        mask = '0;
        mask[W*r +: W] = m;
        exp_q_queue.push_back({12'h000, eq});
        @(negedge clk);
        check({tag, "_gnt"}, {13'h0, gnt}, {13'h0, g});
        check({tag, "_busy"}, {15'h0, busy}, 16'h0001);
        check({tag, "_done_early"}, {15'h0, done}, 16'h0000);
        req  = '0;
        op   = ~op;
        mask = ~mask;
        @(negedge clk);
        pop_q(e);
        check({tag, "_done"}, {15'h0, done}, 16'h0001);
        check({tag, "_q"}, {12'h0, q}, e);
        check({tag, "_qbar"}, {12'h0, q_bar}, {12'h0, ~e[3:0]});
        check({tag, "_gnt_clr"}, {13'h0, gnt}, 16'h0000);
        op   = '0;
        mask = '0;
        @(negedge clk);
        check({tag, "_done_pulse"}, {15'h0, done}, 16'h0000);
    endtask

    initial begin
        logic [15:0] e;
        rst  = 1'b1;
        req  = '0;
        op   = '0;
        mask = '0;
        repeat (2) @(negedge clk);
        check("rst_q", {12'h0, q}, 16'h0000);
        check("rst_qbar", {12'h0, q_bar}, 16'h000f);
        check("rst_gnt", {13'h0, gnt}, 16'h0000);
        check("rst_done", {15'h0, done}, 16'h0000);
        check("rst_busy", {15'h0, busy}, 16'h0000);
        rst = 1'b0;

        // Reset in the middle of a pending set of all bits.
        req  = 3'b001;
        op   = 6'b000010;
        mask = 12'h00f;
        @(negedge clk);
        check("abort_gnt", {13'h0, gnt}, 16'h0001);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("abort_q", {12'h0, q}, 16'h0000);
        check("abort_done", {15'h0, done}, 16'h0000);
        check("abort_gnt_clr", {13'h0, gnt}, 16'h0000);
        check("abort_busy", {15'h0, busy}, 16'h0000);
        rst = 1'b0;
        op   = '0;
        mask = '0;
        @(negedge clk);
        check("abort_done_after", {15'h0, done}, 16'h0000);
        check("abort_q_after", {12'h0, q}, 16'h0000);

        txn(1, 2'b10, 4'b0101, 4'b0101, "set1");
        txn(0, 2'b11, 4'b0011, 4'b0110, "tgl0");
        txn(2, 2'b01, 4'b0100, 4'b0010, "clr2");

        // Round robin: all requesters hold req with zero masks from ptr = 0.
        exp_g_queue.push_back(16'h0001);
        exp_g_queue.push_back(16'h0002);
        exp_g_queue.push_back(16'h0004);
        exp_g_queue.push_back(16'h0001);
        exp_g_queue.push_back(16'h0002);
        exp_g_queue.push_back(16'h0004);
        req  = 3'b111;
        op   = '0;
        mask = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                pop_g(e);
                check("rr_gnt", {13'h0, gnt}, e);
                check("rr_done_odd", {15'h0, done}, 16'h0000);
            end else begin
                check("rr_gnt_gap", {13'h0, gnt}, 16'h0000);
                check("rr_done_even", {15'h0, done}, 16'h0001);
                check("rr_q", {12'h0, q}, 16'h0002);
            end
        end
        req = '0;
        @(negedge clk);
        check("rr_idle_gnt", {13'h0, gnt}, 16'h0000);
        check("rr_idle_done", {15'h0, done}, 16'h0000);

        // Set is applied even though op becomes clear during GRANT.
        txn(0, 2'b10, 4'b1000, 4'b1010, "sample0");

`ifdef JK_BANK_CTRL_COUNT_EN
        txn(0, 2'b01, 4'b1111, 4'b0000, "cnt_clr");
        txn(0, 2'b10, 4'b1110, 4'b1110, "cnt_set");
        txn(0, 2'b00, 4'b1111, 4'b1111, "cnt_inc1");
        txn(0, 2'b00, 4'b1111, 4'b0000, "cnt_wrap");
        txn(0, 2'b10, 4'b0010, 4'b0010, "cnt_set2");
        txn(0, 2'b00, 4'b1010, 4'b1000, "cnt_sparse");
`else
        txn(1, 2'b00, 4'b1111, 4'b1010, "hold1");
        txn(2, 2'b00, 4'b0000, 4'b1010, "zero_mask");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
